// File: rtl/snx_mem_pkg.sv
// Shared constants for the snx memory and I/O responder.
// Imported by the RAM macro and the top level.
package snx_mem_pkg;

  localparam int IO_BIT     = 15;
  localparam int LED_W      = 8;
  localparam int SW_W       = 8;
  localparam int WORD_W     = 16;
  localparam int DEF_ADDR_W = 10;

  localparam logic LD_IMEM = 1'b0;
  localparam logic LD_DMEM = 1'b1;

endpackage

// File: rtl/snx_ram.sv
// Single-clock RAM: falling-edge write, registered falling-edge read.
// Read returns the old word when read and write hit the same address.
module snx_ram
  import snx_mem_pkg::*;
#(
  parameter int AW = DEF_ADDR_W,
  parameter int DW = WORD_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  // Contents survive reset; writes are only blocked while it is held.
  always_ff @(negedge clk) begin
    if (we && rst_n) mem_q[waddr] <= wdata;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/snx_mem_io.sv
// Memory and I/O responder for the snx 16-bit CPU bus.
// Instruction/data RAMs, switch/LED page, loader port, halt and cycle count.
module snx_mem_io
  import snx_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = 32
) (
  input  logic              m_clock,
  input  logic              p_reset,
  input  logic [15:0]       iadrs,
  input  logic              inst_read,
  output logic [15:0]       inst,
  input  logic [15:0]       adrs,
  input  logic [15:0]       datao,
  input  logic              memory_read,
  input  logic              memory_write,
  output logic [15:0]       datai,
  input  logic              hlt,
  input  logic [7:0]        sw,
  output logic [7:0]        led,
  input  logic              ld_we,
  input  logic              ld_sel,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [15:0]       ld_data,
  output logic              ld_ack,
  output logic              halted,
  output logic [CNT_W-1:0]  cycles
);

  logic              io_sel;
  logic              d_rd;
  logic              d_wr;
  logic              ld_i_acc;
  logic              ld_d_acc;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_waddr;
  logic [15:0]       dm_wdata;
  logic [15:0]       dm_rdata;

  logic [SW_W-1:0]   sw_meta_q, sw_meta_d;
  logic [SW_W-1:0]   sw_s_q, sw_s_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic              dsel_q, dsel_d;
  logic [SW_W-1:0]   dio_q, dio_d;
  logic              ld_ack_q, ld_ack_d;
  logic              halted_q, halted_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d;

  logic unused_adrs;
  assign unused_adrs = ^{iadrs[15:ADDR_W], adrs[14:ADDR_W]};

  always_comb begin
    io_sel   = adrs[IO_BIT];
    d_rd     = memory_read && !io_sel;
    d_wr     = memory_write && !io_sel;
    ld_i_acc = ld_we && (ld_sel == LD_IMEM) && !inst_read;
    ld_d_acc = ld_we && (ld_sel == LD_DMEM) && !(d_rd || d_wr);
    dm_we    = d_wr || ld_d_acc;
    dm_waddr = d_wr ? adrs[ADDR_W-1:0] : ld_addr;
    dm_wdata = d_wr ? datao : ld_data;
  end

  always_comb begin
    sw_meta_d = sw;
    sw_s_d    = sw_meta_q;
    led_d     = led_q;
    dsel_d    = dsel_q;
    dio_d     = dio_q;
    ld_ack_d  = ld_i_acc || ld_d_acc;
    halted_d  = halted_q || hlt;
    cycles_d  = cycles_q;
    if (memory_write && io_sel) led_d = datao[LED_W-1:0];
    if (memory_read) dsel_d = io_sel;
    if (memory_read && io_sel) dio_d = sw_s_q;
    if (!halted_q) cycles_d = cycles_q + CNT_W'(1);
  end

  always_ff @(negedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      sw_meta_q <= '0;
      sw_s_q    <= '0;
      led_q     <= '0;
      dsel_q    <= 1'b0;
      dio_q     <= '0;
      ld_ack_q  <= 1'b0;
      halted_q  <= 1'b0;
      cycles_q  <= '0;
    end else begin
      sw_meta_q <= sw_meta_d;
      sw_s_q    <= sw_s_d;
      led_q     <= led_d;
      dsel_q    <= dsel_d;
      dio_q     <= dio_d;
      ld_ack_q  <= ld_ack_d;
      halted_q  <= halted_d;
      cycles_q  <= cycles_d;
    end
  end

  snx_ram #(.AW(ADDR_W), .DW(WORD_W)) u_imem (
    .clk   (m_clock),
    .rst_n (p_reset),
    .re    (inst_read),
    .raddr (iadrs[ADDR_W-1:0]),
    .we    (ld_i_acc),
    .waddr (ld_addr),
    .wdata (ld_data),
    .rdata (inst)
  );

  snx_ram #(.AW(ADDR_W), .DW(WORD_W)) u_dmem (
    .clk   (m_clock),
    .rst_n (p_reset),
    .re    (d_rd),
    .raddr (adrs[ADDR_W-1:0]),
    .we    (dm_we),
    .waddr (dm_waddr),
    .wdata (dm_wdata),
    .rdata (dm_rdata)
  );

  assign datai  = dsel_q ? {8'h00, dio_q} : dm_rdata;
  assign led    = led_q;
  assign ld_ack = ld_ack_q;
  assign halted = halted_q;
  assign cycles = cycles_q;

endmodule

// File: tb/tb_snx_mem_io.sv
// Directed self-checking bench for snx_mem_io.
// Inputs change on rising edges; outputs are checked on rising edges.
module tb_snx_mem_io;

  logic        m_clock;
  logic        p_reset;
  logic [15:0] iadrs;
  logic        inst_read;
  logic [15:0] inst;
  logic [15:0] adrs;
  logic [15:0] datao;
  logic        memory_read;
  logic        memory_write;
  logic [15:0] datai;
  logic        hlt;
  logic [7:0]  sw;
  logic [7:0]  led;
  logic        ld_we;
  logic        ld_sel;
  logic [9:0]  ld_addr;
  logic [15:0] ld_data;
  logic        ld_ack;
  logic        halted;
  logic [31:0] cycles;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_cyc;
  logic        exp_halt;

  snx_mem_io dut (
    .m_clock      (m_clock),
    .p_reset      (p_reset),
    .iadrs        (iadrs),
    .inst_read    (inst_read),
    .inst         (inst),
    .adrs         (adrs),
    .datao        (datao),
    .memory_read  (memory_read),
    .memory_write (memory_write),
    .datai        (datai),
    .hlt          (hlt),
    .sw           (sw),
    .led          (led),
    .ld_we        (ld_we),
    .ld_sel       (ld_sel),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .ld_ack       (ld_ack),
    .halted       (halted),
    .cycles       (cycles)
  );

  initial begin
    m_clock = 1'b0;
    forever #5 m_clock = ~m_clock;
  end

  // Reference cycle counter: counts falling edges until hlt is seen.
  always @(negedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      exp_cyc  = 0;
      exp_halt = 1'b0;
    end else begin
      if (!exp_halt) exp_cyc = exp_cyc + 1;
      if (hlt) exp_halt = 1'b1;
    end
  end

  task automatic tick();
    @(negedge m_clock);
    @(posedge m_clock);
  endtask

  task automatic idle();
    inst_read    = 1'b0;
    memory_read  = 1'b0;
    memory_write = 1'b0;
    ld_we        = 1'b0;
    hlt          = 1'b0;
  endtask

  task automatic test_reset_state();
    checks++;
    if ({inst, datai, led, ld_ack, halted, cycles} !== '0) begin
      errors++;
      $display("FAIL reset_state: got inst=%h datai=%h led=%h ack=%b hlt=%b cyc=%0d expected all 0",
               inst, datai, led, ld_ack, halted, cycles);
    end
    @(posedge m_clock);
    p_reset = 1'b1;
    tick();
    checks++;
    if (cycles !== 32'd1) begin
      errors++;
      $display("FAIL first_cycle: got %0d expected 1", cycles);
    end
  endtask

  task automatic test_load_fetch();
    ld_we = 1'b1; ld_sel = 1'b0; ld_addr = 10'd3; ld_data = 16'hA5C3;
    tick();
    checks++;
    if (ld_ack !== 1'b1) begin
      errors++;
      $display("FAIL imem_ack: got %b expected 1", ld_ack);
    end
    ld_addr = 10'd4; ld_data = 16'h1111;
    tick();
    ld_we = 1'b0;
    tick();
    checks++;
    if (ld_ack !== 1'b0) begin
      errors++;
      $display("FAIL imem_ack_drop: got %b expected 0", ld_ack);
    end
    inst_read = 1'b1; iadrs = 16'd4;
    tick();
    checks++;
    if (inst !== 16'h1111) begin
      errors++;
      $display("FAIL fetch4: got %h expected 1111", inst);
    end
    inst_read = 1'b0; iadrs = 16'd3;
    tick();
    checks++;
    if (inst !== 16'h1111) begin
      errors++;
      $display("FAIL fetch_hold: got %h expected 1111", inst);
    end
    inst_read = 1'b1;
    tick();
    checks++;
    if (inst !== 16'hA5C3) begin
      errors++;
      $display("FAIL fetch3: got %h expected a5c3", inst);
    end
    iadrs = 16'd4;
    tick();
    iadrs = 16'h0403;
    tick();
    inst_read = 1'b0;
    checks++;
    if (inst !== 16'hA5C3) begin
      errors++;
      $display("FAIL fetch_alias: got %h expected a5c3", inst);
    end
  endtask

  task automatic test_store_load();
    memory_write = 1'b1; adrs = 16'h0010; datao = 16'h1234;
    tick();
    adrs = 16'h0001; datao = 16'h0F0F;
    tick();
    memory_write = 1'b0; memory_read = 1'b1; adrs = 16'h0010;
    tick();
    checks++;
    if (datai !== 16'h1234) begin
      errors++;
      $display("FAIL load_1234: got %h expected 1234", datai);
    end
    memory_write = 1'b1; datao = 16'hBEEF;
    tick();
    checks++;
    if (datai !== 16'h1234) begin
      errors++;
      $display("FAIL rbw_old: got %h expected 1234", datai);
    end
    memory_write = 1'b0;
    tick();
    checks++;
    if (datai !== 16'hBEEF) begin
      errors++;
      $display("FAIL rbw_new: got %h expected beef", datai);
    end
    adrs = 16'h0001;
    tick();
    adrs = 16'h0410;
    tick();
    memory_read = 1'b0;
    checks++;
    if (datai !== 16'hBEEF) begin
      errors++;
      $display("FAIL dmem_alias: got %h expected beef", datai);
    end
  endtask

  task automatic test_io();
    sw = 8'h34;
    tick();
    tick();
    memory_read = 1'b1; adrs = 16'h8000;
    tick();
    checks++;
    if (datai !== 16'h0034) begin
      errors++;
      $display("FAIL sw_34: got %h expected 0034", datai);
    end
    sw = 8'h77;
    tick();
    checks++;
    if (datai !== 16'h0034) begin
      errors++;
      $display("FAIL sw_sync1: got %h expected 0034", datai);
    end
    tick();
    checks++;
    if (datai !== 16'h0034) begin
      errors++;
      $display("FAIL sw_sync2: got %h expected 0034", datai);
    end
    tick();
    checks++;
    if (datai !== 16'h0077) begin
      errors++;
      $display("FAIL sw_sync3: got %h expected 0077", datai);
    end
    memory_read = 1'b0; memory_write = 1'b1;
    adrs = 16'h8001; datao = 16'hFF5A;
    tick();
    checks++;
    if (led !== 8'h5A) begin
      errors++;
      $display("FAIL led_5a: got %h expected 5a", led);
    end
    memory_write = 1'b0; memory_read = 1'b1; adrs = 16'h0001;
    tick();
    memory_read = 1'b0;
    checks++;
    if (datai !== 16'h0F0F) begin
      errors++;
      $display("FAIL io_no_dmem: got %h expected 0f0f", datai);
    end
  endtask

  task automatic test_loader_contention();
    memory_write = 1'b1; adrs = 16'h0020; datao = 16'h2222;
    ld_we = 1'b1; ld_sel = 1'b1; ld_addr = 10'h021; ld_data = 16'h3333;
    tick();
    checks++;
    if (ld_ack !== 1'b0) begin
      errors++;
      $display("FAIL ld_blocked: got %b expected 0", ld_ack);
    end
    memory_write = 1'b0;
    tick();
    checks++;
    if (ld_ack !== 1'b1) begin
      errors++;
      $display("FAIL ld_after: got %b expected 1", ld_ack);
    end
    memory_write = 1'b1; adrs = 16'h8000; datao = 16'h00C3;
    ld_addr = 10'h022; ld_data = 16'h4444;
    tick();
    checks++;
    if ({ld_ack, led} !== {1'b1, 8'hC3}) begin
      errors++;
      $display("FAIL ld_io_ok: got ack=%b led=%h expected ack=1 led=c3", ld_ack, led);
    end
    memory_write = 1'b0; ld_we = 1'b0;
    memory_read = 1'b1; adrs = 16'h0020;
    tick();
    checks++;
    if (datai !== 16'h2222) begin
      errors++;
      $display("FAIL cont_store: got %h expected 2222", datai);
    end
    adrs = 16'h0021;
    tick();
    checks++;
    if (datai !== 16'h3333) begin
      errors++;
      $display("FAIL cont_ld: got %h expected 3333", datai);
    end
    adrs = 16'h0022;
    tick();
    memory_read = 1'b0;
    checks++;
    if (datai !== 16'h4444) begin
      errors++;
      $display("FAIL io_ld: got %h expected 4444", datai);
    end
  endtask

  task automatic test_halt();
    for (int i = 0; i < 100; i++) tick();
    checks++;
    if ({halted, cycles} !== {1'b0, exp_cyc}) begin
      errors++;
      $display("FAIL pre_halt: got hlt=%b cyc=%0d expected hlt=0 cyc=%0d", halted, cycles, exp_cyc);
    end
    hlt = 1'b1;
    tick();
    hlt = 1'b0;
    checks++;
    if ({halted, cycles} !== {1'b1, exp_cyc}) begin
      errors++;
      $display("FAIL halt_set: got hlt=%b cyc=%0d expected hlt=1 cyc=%0d", halted, cycles, exp_cyc);
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if ({halted, cycles} !== {1'b1, exp_cyc}) begin
      errors++;
      $display("FAIL halt_freeze: got hlt=%b cyc=%0d expected hlt=1 cyc=%0d", halted, cycles, exp_cyc);
    end
    memory_read = 1'b1; adrs = 16'h0020;
    tick();
    memory_read = 1'b0;
    checks++;
    if (datai !== 16'h2222) begin
      errors++;
      $display("FAIL halt_load: got %h expected 2222", datai);
    end
    memory_write = 1'b1; adrs = 16'h8000; datao = 16'h005A;
    ld_we = 1'b1; ld_sel = 1'b1; ld_addr = 10'h030; ld_data = 16'h5555;
    tick();
    memory_write = 1'b0; ld_we = 1'b0;
    checks++;
    if ({ld_ack, led} !== {1'b1, 8'h5A}) begin
      errors++;
      $display("FAIL halt_ld_st: got ack=%b led=%h expected ack=1 led=5a", ld_ack, led);
    end
  endtask

  task automatic test_reset_mid();
    memory_read = 1'b1; adrs = 16'h0030;
    inst_read = 1'b1; iadrs = 16'd4;
    tick();
    memory_write = 1'b1; adrs = 16'h0020; datao = 16'hDEAD;
    #2;
    p_reset = 1'b0;
    #1;
    checks++;
    if ({inst, datai, led, ld_ack, halted, cycles} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got inst=%h datai=%h led=%h ack=%b hlt=%b cyc=%0d expected all 0",
               inst, datai, led, ld_ack, halted, cycles);
    end
    tick();
    tick();
    idle();
    p_reset = 1'b1;
    memory_read = 1'b1; adrs = 16'h0020;
    inst_read = 1'b1; iadrs = 16'd3;
    tick();
    idle();
    checks++;
    if ({datai, inst, cycles} !== {16'h2222, 16'hA5C3, 32'd1}) begin
      errors++;
      $display("FAIL reset_retain: got datai=%h inst=%h cyc=%0d expected 2222 a5c3 1",
               datai, inst, cycles);
    end
  endtask

  initial begin
    p_reset = 1'b0;
    idle();
    iadrs   = '0;
    adrs    = '0;
    datao   = '0;
    sw      = '0;
    ld_sel  = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    #12;
    test_reset_state();
    test_load_fetch();
    test_store_load();
    test_io();
    test_loader_contention();
    test_halt();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/snx_mem_io.md
# snx_mem_io

Synthesizable memory and I/O responder for the `snx` 16-bit CPU bus. It supplies instruction words on the fetch port and serves data loads and stores. Bit 15 of the data address selects between data RAM and the switch/LED I/O page. It adds a program-load port, a two-flop switch synchronizer, a sticky halt flag and a run-cycle counter, so the CPU can run on hardware without a behavioural memory model.

## Interface
Parameters:
- `ADDR_W`, 10: word-address bits per RAM; depth is 2**ADDR_W.
- `CNT_W`, 32: width of the cycle counter.

Ports:
- `m_clock` in 1: single clock; all state updates on the falling edge.
- `p_reset` in 1: asynchronous, active-low reset.
- `iadrs` in 16: instruction word address from the CPU.
- `inst_read` in 1: instruction fetch strobe.
- `inst` out 16: fetched instruction word.
- `adrs` in 16: data address; bit 15 set selects I/O.
- `datao` in 16: store data from the CPU.
- `memory_read` in 1: load strobe.
- `memory_write` in 1: store strobe.
- `datai` out 16: load data to the CPU.
- `hlt` in 1: CPU halt indication.
- `sw` in 8: asynchronous switch inputs.
- `led` out 8: LED register.
- `ld_we` in 1: loader write request.
- `ld_sel` in 1: loader target; 0 is instruction RAM, 1 is data RAM.
- `ld_addr` in ADDR_W: loader word address.
- `ld_data` in 16: loader data.
- `ld_ack` out 1: one-cycle pulse when a loader write is accepted.
- `halted` out 1: sticky halt flag.
- `cycles` out CNT_W: falling edges counted since reset while not halted.

## Operation
- **RAM indexing:** both RAMs use `iadrs`/`adrs` bits [ADDR_W-1:0]. Bits above ADDR_W and below 15 are ignored, so addresses alias.
- **Fetch:** when `inst_read` is high, `inst` takes imem[iadrs]. Otherwise `inst` holds its value.
- **Load, RAM page:** when `memory_read` is high and adrs[15]=0, `datai` takes dmem[adrs].
- **Load, I/O page:** when `memory_read` is high and adrs[15]=1, `datai` takes {8'h00, sw_s}. `sw_s` is the second synchronizer stage.
- **Store:** when `memory_write` is high, adrs[15]=0 writes dmem[adrs] with `datao`; adrs[15]=1 sets `led` to datao[7:0].
- **Read and write in the same cycle to the same dmem word:** the store is performed and `datai` returns the old word (read-before-write).
- **Loader:**
  - imem target: `ld_we` is accepted in any cycle where `inst_read` is low.
  - dmem target: `ld_we` is accepted in any cycle where neither `memory_read` nor `memory_write` is high with adrs[15]=0.
  - An accepted write updates the RAM and pulses `ld_ack` high for that one cycle.
  - A rejected request gets no ack. The loader holds `ld_we`, `ld_sel`, `ld_addr` and `ld_data` stable until it sees the ack.
- **Halt:** `hlt` high sets `halted`. Only reset clears it. Once `halted` is set, `cycles` freezes. Loads, stores and loader writes continue to operate after halt.
- **Counter:** `cycles` wraps modulo 2**CNT_W.

## Timing
- All registers update on the falling edge of `m_clock`. A strobe sampled at falling edge N has its data on `inst`/`datai` at the following rising edge, which is where the CPU samples it.
- Load and fetch latency: a half cycle after the strobe edge; one full cycle from the strobe's launch.
- Store: RAM or `led` is visible at the falling edge where `memory_write` is sampled.
- Switch path: a change on `sw` reaches `datai` no earlier than the third falling edge after the change.
- Reset values, applied asynchronously while `p_reset`=0:
  - `inst`=0, `datai`=0, `led`=0, sync flops=0, `ld_ack`=0, `halted`=0, `cycles`=0.
  - RAM contents are not reset.
- Reset asserted mid-operation: pending strobes are dropped and no partial writes occur after `p_reset` falls. The loader must re-request any write that was not acked.
- On the first falling edge after `p_reset` rises, `cycles` becomes 1.

## Structure
- Package `snx_mem_pkg` holds:
  - `IO_BIT`=15
  - `LED_W`=8, `SW_W`=8
  - `WORD_W`=16
  - default `ADDR_W`
  - `LD_IMEM`=0, `LD_DMEM`=1
- Sub-module `snx_ram`: single-clock RAM, falling-edge write, registered falling-edge read, read-before-write. It is instantiated twice, once for imem and once for dmem. The write-enable and address muxes between CPU and loader stay in the top level.

## Test plan
- **Load and fetch:** loader writes imem[3]=16'hA5C3 (check `ld_ack` pulse), then `inst_read` with `iadrs`=3 → `inst`=A5C3 one cycle later. Repeat with `iadrs`=16'h0403 and check aliasing to the same word.
- **Store/load:** store 16'h1234 to adrs 16'h0010, then load adrs 16'h0010 → `datai`=1234. Same-cycle load and store of 16'hBEEF to 0x0010 → `datai`=1234, and the next load returns BEEF.
- **I/O:** `sw`=8'h34, wait 3 edges, load adrs 16'h8000 → `datai`=0034. Store 16'hFF5A to 16'h8001 → `led`=5A, dmem unchanged.
- **Loader contention:** `ld_we` to dmem while `memory_write` targets RAM → no ack that cycle. Ack arrives the cycle after the store ends, and both writes are present.
- **Halt:** after 100 cycles pulse `hlt` → `halted`=1 and `cycles` freezes at its value. Subsequent loads still work.
- **Reset:** assert `p_reset`=0 mid-load with `led`=5A and `cycles`≠0 → all outputs zero immediately, RAM contents retained.
